shift_sequencer: RTL and testbench

//   Control stage directly upstream of shift_register. Accepts one shift job
//   (operand, op, amount) over valid/ready, loads it into a shift_register

---
 rtl/shift_sequencer.sv | 120 ++++++++++++
 tb/tb_shift_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Sequencer that turns a single-step shift_register into a multi-bit shifter/rotator.
// It accepts one job, loads the register, issues one shift per cycle, then returns the result and carry.
module shift_sequencer #(
  parameter int W     = 8,
  parameter int AMT_W = $clog2(W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_carry,
  output logic [W-1:0]     sr_parallel_in,
  output logic             sr_serial_in,
  output logic             sr_lshift,
  output logic             sr_rshift,
  output logic             sr_load,
  output logic             sr_en,
  input  logic [W-1:0]     sr_parallel_out,
  input  logic             sr_serial_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL} op_t;

  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(W);

  state_t           state, next_state;
  op_t              op;
  logic [AMT_W-1:0] cnt;
  logic             carry;
  logic [AMT_W-1:0] clamped_amt;
  logic             accept;

  assign clamped_amt = (in_amt > W_AMT) ? W_AMT : in_amt;
  assign accept      = (state == IDLE) && in_valid && !rst;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= OP_SLL;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (in_valid) begin
          op    <= op_t'(in_op);
          cnt   <= clamped_amt;
          carry <= 1'b0;
        end
        SHIFT: begin
          carry <= sr_serial_out;
          cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    next_state     = state;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_carry      = 1'b0;
    sr_parallel_in = '0;
    sr_serial_in   = 1'b0;
    sr_lshift      = 1'b0;
    sr_rshift      = 1'b0;
    sr_load        = 1'b0;
    sr_en          = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (accept) begin
            // Load happens on the accept edge so the first shift can follow immediately.
            sr_load        = 1'b1;
            sr_en          = 1'b1;
            sr_parallel_in = in_data;
            next_state     = (clamped_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          sr_en = 1'b1;
          case (op)
            OP_SLL: sr_lshift = 1'b1;
            OP_SRL: sr_rshift = 1'b1;
            OP_SRA: begin
              sr_rshift    = 1'b1;
              sr_serial_in = sr_parallel_out[W-1];
            end
            OP_ROL: begin
              sr_lshift    = 1'b1;
              sr_serial_in = sr_serial_out;
            end
            default: ;
          endcase
          if (cnt == AMT_W'(1)) next_state = DONE;
        end
        DONE: begin
          out_valid = 1'b1;
          out_data  = sr_parallel_out;
          out_carry = carry;
          if (out_ready) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a stand-in shift_register and an arithmetic reference model.
module tb_shift_sequencer;

  localparam int W     = 8;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [1:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_carry;
  logic [W-1:0]     sr_parallel_in;
  logic             sr_serial_in;
  logic             sr_lshift;
  logic             sr_rshift;
  logic             sr_load;
  logic             sr_en;
  logic [W-1:0]     sr_parallel_out;
  logic             sr_serial_out;

  int checks   = 0;
  int failures = 0;
  int both_dir = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.W(W), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
    .sr_parallel_in(sr_parallel_in), .sr_serial_in(sr_serial_in),
    .sr_lshift(sr_lshift), .sr_rshift(sr_rshift), .sr_load(sr_load), .sr_en(sr_en),
    .sr_parallel_out(sr_parallel_out), .sr_serial_out(sr_serial_out)
  );

  // Stand-in shift_register: load wins, then one shift left or right; serialOut is the bit leaving.
  logic [W-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (sr_en) begin
      if (sr_load)        sr_q <= sr_parallel_in;
      else if (sr_lshift) sr_q <= {sr_q[W-2:0], sr_serial_in};
      else if (sr_rshift) sr_q <= {sr_serial_in, sr_q[W-1:1]};
    end
  end
  assign sr_parallel_out = sr_q;
  assign sr_serial_out   = sr_lshift ? sr_q[W-1] : (sr_rshift ? sr_q[0] : 1'b0);

  always @(negedge clk) if (sr_lshift && sr_rshift) both_dir++;

  // Reference: whole-operand arithmetic; returns {carry, result}.
  function automatic logic [8:0] ref_shift(input logic [1:0] op, input logic [7:0] d, input int amt);
    int n, r, c, sd;
    n  = (amt > 8) ? 8 : amt;
    sd = {{24{d[7]}}, d};
    r  = 0;
    c  = 0;
    case (op)
      2'b00: begin r = (int'(d) << n) & 8'hFF; c = (n == 0) ? 0 : (int'(d) >> (8 - n)) & 1; end
      2'b01: begin r = int'(d) >> n;           c = (n == 0) ? 0 : (int'(d) >> (n - 1)) & 1; end
      2'b10: begin r = (sd >>> n) & 8'hFF;     c = (n == 0) ? 0 : (sd >>> (n - 1)) & 1; end
      default: begin
        r = ((int'(d) << n) | (int'(d) >> (8 - n))) & 8'hFF;
        c = (n == 0) ? 0 : (int'(d) >> (8 - n)) & 1;
      end
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job end to end; assumes the caller is 1 time unit after an edge with the DUT idle.
  task automatic run_job(input logic [1:0] op, input logic [7:0] d, input logic [3:0] amt, input string name);
    logic [8:0] exp;
    int lat, exp_lat;
    exp     = ref_shift(op, d, int'(amt));
    exp_lat = ((amt > 8) ? 8 : int'(amt)) + 1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept: got %b expected 1", name, in_ready);
    end
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = amt;
    tick();
    in_valid = 1'b0; in_data = $urandom; in_op = $urandom; in_amt = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s ready_while_busy: got %b expected 0", name, in_ready);
      end
      tick();
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (out_data !== exp[7:0]) begin
      failures++;
      $display("FAIL %s data: got %h expected %h", name, out_data, exp[7:0]);
    end
    checks++;
    if (out_carry !== exp[8]) begin
      failures++;
      $display("FAIL %s carry: got %b expected %b", name, out_carry, exp[8]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s return_to_idle: got valid=%b ready=%b expected valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || sr_en !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: got ready=%b en=%b valid=%b expected 0 0 0", in_ready, sr_en, out_valid);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    tick();
  endtask

  task automatic test_directed();
    run_job(2'b00, 8'h81, 4'd3, "sll_81_3");
    run_job(2'b10, 8'h90, 4'd2, "sra_90_2");
    run_job(2'b01, 8'h03, 4'd1, "srl_03_1");
    run_job(2'b11, 8'hA5, 4'd4, "rol_a5_4");
    run_job(2'b11, 8'hA5, 4'd9, "rol_a5_9");
    run_job(2'b00, 8'hFF, 4'd8, "sll_ff_8");
    run_job(2'b01, 8'hFF, 4'd15, "srl_ff_15");
    run_job(2'b10, 8'h80, 4'd12, "sra_80_12");
  endtask

  task automatic test_hold();
    in_valid = 1'b1; in_op = 2'b00; in_data = 8'h3C; in_amt = 4'd0;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_carry !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got valid=%b data=%h carry=%b ready=%b expected 1 3c 0 0",
                 i, out_valid, out_data, out_carry, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_job();
    in_valid = 1'b1; in_op = 2'b01; in_data = 8'hF0; in_amt = 4'd6;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (sr_en !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got en=%b ready=%b valid=%b expected 0 0 0", sr_en, in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_idle: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_no_result: got valid=%b expected 0", out_valid);
      end
    end
    run_job(2'b01, 8'hF0, 4'd4, "srl_f0_4_after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_job(2'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_direction_exclusive();
    checks++;
    if (both_dir != 0) begin
      failures++;
      $display("FAIL lshift_rshift_exclusive: got %0d overlapping cycles expected 0", both_dir);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_job();
    test_random();
    test_direction_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
